// File: rtl/uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx: LSB-first UART serialiser (start, data, optional parity, stop).
// Define UART_TX_TWO_STOP_EN for two stop bits.             Revision: 1.0
// ----------------------------------------------------------------------------
module uart_tx #(
   parameter int DWIDTH = 8,
   parameter int PWIDTH = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] p_data,
   input  logic              data_valid,
   input  logic              parity_en,
   input  logic              parity_type,
   input  logic [PWIDTH-1:0] prescale,
   output logic              s_data,
   output logic              busy
);

   localparam int IW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DWIDTH - 1);
`ifdef UART_TX_TWO_STOP_EN
   localparam logic TWO_STOP = 1'b1;
`else
   localparam logic TWO_STOP = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [DWIDTH-1:0] data_q;
   logic              par_en_q, par_type_q;
   logic [PWIDTH-1:0] period_q;
   logic [PWIDTH-1:0] cyc_cnt, cyc_n;
   logic [IW-1:0]     bit_idx, idx_n;
   logic              stop_cnt, stop_n;
   logic              s_data_n, busy_n, load, bit_done;

   assign bit_done = (cyc_cnt == period_q - PWIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cyc_cnt    <= '0;
         bit_idx    <= '0;
         stop_cnt   <= 1'b0;
         s_data     <= 1'b1;
         busy       <= 1'b0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         period_q   <= '0;
      end else begin
         state    <= state_n;
         cyc_cnt  <= cyc_n;
         bit_idx  <= idx_n;
         stop_cnt <= stop_n;
         s_data   <= s_data_n;
         busy     <= busy_n;
         if (load) begin
            data_q     <= p_data;
            par_en_q   <= parity_en;
            par_type_q <= parity_type;
            // A zero prescale still needs a one-cycle bit to make progress
            period_q   <= (prescale == '0) ? PWIDTH'(1) : prescale;
         end
      end
   end

   always_comb begin
      state_n = state;
      cyc_n   = cyc_cnt;
      idx_n   = bit_idx;
      stop_n  = stop_cnt;
      load    = 1'b0;
      if (state == IDLE) begin
         cyc_n  = '0;
         idx_n  = '0;
         stop_n = 1'b0;
         if (data_valid) begin
            state_n = START;
            load    = 1'b1;
         end
      end else begin
         cyc_n = bit_done ? '0 : cyc_cnt + PWIDTH'(1);
         if (bit_done) begin
            case (state)
               START: begin
                  state_n = DATA;
                  idx_n   = '0;
               end
               DATA: begin
                  if (bit_idx == LAST_IDX) begin
                     state_n = par_en_q ? PARITY : STOP;
                     stop_n  = 1'b0;
                  end else begin
                     idx_n = bit_idx + IW'(1);
                  end
               end
               PARITY: begin
                  state_n = STOP;
                  stop_n  = 1'b0;
               end
               STOP: begin
                  if (TWO_STOP && !stop_cnt) stop_n = 1'b1;
                  else                       state_n = IDLE;
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

   // Outputs are decoded from the next state so they register in step with it
   always_comb begin
      s_data_n = 1'b1;
      busy_n   = (state_n != IDLE);
      case (state_n)
         START:   s_data_n = 1'b0;
         DATA:    s_data_n = data_q[idx_n];
         PARITY:  s_data_n = (^data_q) ^ par_type_q;
         default: s_data_n = 1'b1;
      endcase
   end

endmodule
`default_nettype wire
